// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back arbiter.
//   DATA_W / ADDR_W / NREGS : register-file geometry (8 x 16, R0 writable)
//   LQ_DEPTH                : load-return FIFO depth (power of two)
//   STARVE_MAX              : ALU wins a queued load may lose before alu_hold
//   wb_src_e                : which source feeds the write port this cycle
//   ld_entry_t              : one queued load return
package wb_pkg;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 3;
    localparam int NREGS      = 8;
    localparam int LQ_DEPTH   = 2;
    localparam int STARVE_MAX = 4;
    localparam int AGE_W      = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LQ   = 2'd2,
        SRC_BYP  = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ld_entry_t;

    localparam int LD_ENTRY_W = ADDR_W + DATA_W;

    // One-hot register mask, all zero when en is low.
    function automatic logic [NREGS-1:0] reg_mask(input logic [ADDR_W-1:0] rd,
                                                  input logic              en);
        logic [NREGS-1:0] one;
        one = NREGS'(1);
        reg_mask = en ? (one << rd) : '0;
    endfunction
endpackage

// File: rtl/wb_arbiter_chk.sv
// Protocol checks for the write-back arbiter (simulation only).
//   alu_valid_i must stay low while alu_hold_i is high.
//   An issue to a register must not find it busy, unless that register is
//   being committed on the same edge.
module wb_arbiter_chk
    import wb_pkg::*;
(
    input logic              clk_i,
    input logic              rst_n_i,
    input logic              alu_valid_i,
    input logic              alu_hold_i,
    input logic              issue_valid_i,
    input logic [ADDR_W-1:0] issue_rd_i,
    input logic [NREGS-1:0]  busy_i,
    input logic              reg_write_i,
    input logic [ADDR_W-1:0] wr_rd_i
);
    a_no_alu_under_hold: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) !(alu_valid_i && alu_hold_i));

    a_no_issue_to_busy: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        !(issue_valid_i && busy_i[issue_rd_i] && !(reg_write_i && (wr_rd_i == issue_rd_i))));
endmodule

// File: rtl/wb_ld_fifo.sv
// Small synchronous FIFO for load returns that lost write-port arbitration.
//   clk, rst_n      : clock, async active-low reset (resets to empty)
//   push_i, din_i   : write an entry (ignored when full)
//   pop_i, dout_o   : drop the head entry (ignored when empty); dout_o = head
//   full_o, empty_o : occupancy flags, purely from registered state
module wb_ld_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [IDX_W-1:0] wr_idx_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (cnt_q == CNT_W'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign dout_o    = mem_q[rd_idx_q];

    // Storage, pointers and occupancy; indices wrap naturally for power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_idx_q] <= din_i;
                wr_idx_q        <= wr_idx_q + IDX_W'(1);
            end
            if (do_pop_s) begin
                rd_idx_q <= rd_idx_q + IDX_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the 8x16 register file.
//   issue_valid/issue_rd         : destination issued this cycle (sets busy)
//   alu_valid/alu_rd/alu_data    : ALU result, always accepted, highest priority
//   ld_valid/ld_rd/ld_data       : load return, accepted when ld_ready
//   ld_ready                     : load FIFO not full
//   alu_hold                     : upstream must keep alu_valid low next cycle
//   reg_write/wr_rd/write_data   : registered register-file write port
//   busy                         : per-register write-pending bits
module wb_arbiter
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              alu_hold,
    output logic              reg_write,
    output logic [ADDR_W-1:0] wr_rd,
    output logic [DATA_W-1:0] write_data,
    output logic [NREGS-1:0]  busy
);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(STARVE_MAX - 1);

    wb_src_e           src_s;
    ld_entry_t         head_s;
    ld_entry_t         ld_in_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              pop_s;
    logic [AGE_W-1:0]  age_q, age_d;
    logic              alu_hold_q, alu_hold_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] wr_rd_q, wr_rd_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    assign ld_in_s  = '{rd: ld_rd, data: ld_data};
    assign ld_ready = !fifo_full_s;

    wb_ld_fifo #(.W(LD_ENTRY_W), .DEPTH(LQ_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .din_i   (ld_in_s),
        .pop_i   (pop_s),
        .dout_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Source selection: ALU, then queued head, then bypass of an incoming load.
    always_comb begin
        src_s = SRC_NONE;
        if (alu_valid) begin
            src_s = SRC_ALU;
        end else if (!fifo_empty_s) begin
            src_s = SRC_LQ;
        end else if (ld_valid) begin
            src_s = SRC_BYP;
        end else begin
            src_s = SRC_NONE;
        end
    end

    // A load is queued only when accepted and not already taking the bypass path.
    assign push_s = ld_valid && !fifo_full_s && (src_s != SRC_BYP);
    assign pop_s  = (src_s == SRC_LQ);

    // Next write-port contents; address/data hold their last value when idle.
    always_comb begin
        reg_write_d  = 1'b0;
        wr_rd_d      = wr_rd_q;
        write_data_d = write_data_q;
        case (src_s)
            SRC_ALU: begin
                reg_write_d  = 1'b1;
                wr_rd_d      = alu_rd;
                write_data_d = alu_data;
            end
            SRC_LQ: begin
                reg_write_d  = 1'b1;
                wr_rd_d      = head_s.rd;
                write_data_d = head_s.data;
            end
            SRC_BYP: begin
                reg_write_d  = 1'b1;
                wr_rd_d      = ld_rd;
                write_data_d = ld_data;
            end
            default: begin
                reg_write_d = 1'b0;
            end
        endcase
    end

    // Starvation tracking: age counts ALU wins over a waiting head; the win
    // that finds age at its last value raises alu_hold, which a pop drops.
    always_comb begin
        age_d      = age_q;
        alu_hold_d = alu_hold_q;
        if (fifo_empty_s || pop_s) begin
            age_d      = '0;
            alu_hold_d = 1'b0;
        end else if (src_s == SRC_ALU) begin
            if (age_q == AGE_LAST) begin
                alu_hold_d = 1'b1;
            end else begin
                age_d = age_q + AGE_W'(1);
            end
        end else begin
            age_d      = age_q;
            alu_hold_d = alu_hold_q;
        end
    end

    // Scoreboard: the commit being written clears, a new issue sets; set wins.
    always_comb begin
        busy_d = (busy_q & ~reg_mask(wr_rd_q, reg_write_q)) | reg_mask(issue_rd, issue_valid);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q        <= '0;
            alu_hold_q   <= 1'b0;
            busy_q       <= '0;
            reg_write_q  <= 1'b0;
            wr_rd_q      <= '0;
            write_data_q <= '0;
        end else begin
            age_q        <= age_d;
            alu_hold_q   <= alu_hold_d;
            busy_q       <= busy_d;
            reg_write_q  <= reg_write_d;
            wr_rd_q      <= wr_rd_d;
            write_data_q <= write_data_d;
        end
    end

    assign alu_hold   = alu_hold_q;
    assign busy       = busy_q;
    assign reg_write  = reg_write_q;
    assign wr_rd      = wr_rd_q;
    assign write_data = write_data_q;

    wb_arbiter_chk u_chk (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .alu_valid_i   (alu_valid),
        .alu_hold_i    (alu_hold_q),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .busy_i        (busy_q),
        .reg_write_i   (reg_write_q),
        .wr_rd_i       (wr_rd_q)
    );
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and scoreboard that drives the single write port of the 8×16 register file. It merges single-cycle ALU results with variable-latency load returns, buffers loads in a small FIFO, enforces a starvation limit on loads, and tracks per-register pending-write (busy) bits for the issue stage's RAW/WAW stall logic.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 3, register address width
- NREGS, 8, number of architectural registers (R0 is an ordinary writable register)
- LQ_DEPTH, 2, load-return FIFO depth (power of two)
- STARVE_MAX, 4, cycles a FIFO head may be blocked before `alu_hold` asserts
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  instruction with a register destination issued this cycle
- issue_rd  in  ADDR_W  destination of the issued instruction
- alu_valid  in  1  ALU result present (no back-pressure; always accepted)
- alu_rd  in  ADDR_W  ALU destination
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load data returning
- ld_rd  in  ADDR_W  load destination
- ld_data  in  DATA_W  load data
- ld_ready  out  1  load return accepted when `ld_valid & ld_ready`
- alu_hold  out  1  upstream must not assert `alu_valid` next cycle
- reg_write  out  1  register-file write enable
- wr_rd  out  ADDR_W  register-file write address
- write_data  out  DATA_W  register-file write data
- busy  out  NREGS  bit i set = write to Ri pending

## Operation
- Every edge, select one source for the registered write port; priority:
  1. ALU, if `alu_valid`
  2. FIFO head, if FIFO not empty
  3. Incoming load bypass, if FIFO empty and `ld_valid`
  4. None: `reg_write` is 0 next cycle
- An accepted load that is not selected is pushed into the FIFO. Push and pop may occur on the same edge.
- `ld_ready` is `!full`. It is combinational from FIFO state only, not from `ld_valid`.
- Starvation counter `age` increments each edge where the FIFO is non-empty and the ALU wins.
  - Clears when the head is popped or the FIFO is empty.
  - `alu_hold` is registered high when `age == STARVE_MAX-1` and the ALU wins again.
  - `alu_hold` stays high until the head is popped.
- `alu_valid` while `alu_hold` is high is a protocol violation. The ALU still wins (data is never dropped), and a simulation assertion fires.
- Scoreboard:
  - `issue_valid` sets `busy[issue_rd]`.
  - A commit (edge latching `reg_write=1` for rd) clears `busy[rd]`.
  - Set and clear of the same rd on the same edge: set wins.
  - Issue to an already-busy rd is a violation; assertion only.
- Write data is a full-width copy, no arithmetic. Addresses wrap within NREGS; no range check.

## Timing
- Reset values: `reg_write`=0, `wr_rd`=0, `write_data`=0, `busy`=0, `alu_hold`=0, FIFO empty (so `ld_ready`=1), `age`=0.
- ALU latency: `alu_valid` in cycle N gives `reg_write`=1 in cycle N+1. The register file updates at the end of N+1, and `busy` clears on that same edge.
- Load latency:
  - Bypass: N+1.
  - Queued: at least N+2, at most N+1+STARVE_MAX+LQ_DEPTH with a compliant upstream.
- Full FIFO with a simultaneous pop: `ld_ready` stays 0 that cycle; no same-cycle refill.
- Reset asserted mid-operation: FIFO contents and busy bits are discarded immediately (asynchronous), and outputs return to reset values. The issue stage is flushed by the same reset.

## Structure
- Package `wb_pkg`: DATA_W, ADDR_W, NREGS constants; enum `wb_src_e {SRC_NONE, SRC_ALU, SRC_LQ, SRC_BYP}`.
- Sub-module `wb_ld_fifo`: synchronous FIFO with push/pop/full/empty, reset to empty. Contains no arbitration logic.
- Top level: select logic, age counter, `alu_hold` register, scoreboard register, output registers.

## Test plan
- Reset, then ALU `alu_rd`=3, `alu_data`=0x0008 in cycle 1 -> `reg_write`=1, `wr_rd`=3, `write_data`=0x0008 in cycle 2; `busy[3]` (issued cycle 0) clears at end of cycle 2.
- Load (rd=5, 0x1234) with the ALU idle and FIFO empty -> bypass, written the next cycle, `ld_ready` stays 1.
- Same-cycle ALU (rd=1, 0x0005) and load (rd=2, 0x0003) -> rd=1 written at N+1, rd=2 at N+2, FIFO occupancy 1 then 0.
- Continuous `alu_valid` with two loads queued -> `ld_ready`=0 while full; `alu_hold`=1 after STARVE_MAX ALU wins; with the ALU then idle, both loads drain in order; `alu_hold` drops after each pop until the FIFO is empty.
- `issue_valid` rd=4 on the same edge as a commit to rd=4 -> `busy[4]` remains 1.
- Assert `rst_n`=0 with 2 loads queued and busy=0x3C -> immediately `busy`=0, `reg_write`=0, `ld_ready`=1; no stale write after release.
